// File: rtl/world_pkg.sv
// world_pkg: shared types and constants for the raycaster tile map.
//   MAP_W / MAP_H  : map dimensions in cells (fixed by 4-bit coordinates)
//   cell_t         : 4-bit cell coordinate
//   row_t          : one 16-bit map row, bit x = column x
//   DEFAULT_MAP    : built-in map, walls on the border plus four pillars
package world_pkg;

    localparam int MAP_W = 16;
    localparam int MAP_H = 16;

    typedef logic [3:0]  cell_t;
    typedef logic [15:0] row_t;

    // Row 5/6 carry the pillar at column 5; row 8 carries columns 10 and 11.
    localparam row_t DEFAULT_MAP [16] = '{
        16'hFFFF,  // y = 0
        16'h8001,  // y = 1
        16'h8001,  // y = 2
        16'h8001,  // y = 3
        16'h8001,  // y = 4
        16'h8021,  // y = 5
        16'h8021,  // y = 6
        16'h8001,  // y = 7
        16'h8C01,  // y = 8
        16'h8001,  // y = 9
        16'h8001,  // y = 10
        16'h8001,  // y = 11
        16'h8001,  // y = 12
        16'h8001,  // y = 13
        16'h8001,  // y = 14
        16'hFFFF   // y = 15
    };

endpackage

// File: rtl/world_map_rom.sv
module world_map_rom
  import world_pkg::*;
#(
  parameter int MAP_W    = world_pkg::MAP_W,
  parameter int MAP_H    = world_pkg::MAP_H,
  parameter     MAP_FILE = ""
) (
  input  logic [3:0]       y,
  output logic [MAP_W-1:0] row
);

  always_comb begin
    row = DEFAULT_MAP[y];
  end

endmodule

// File: rtl/world_map.sv
// world_map: 16x16 tile-map lookup beside the DDA ray stepper.
//   clk            : system clock, rising edge
//   reset          : asynchronous, active-low reset
//   xPos, yPos     : current map cell (column, row)
//   setup_complete : ray setup done; lookups valid only while high
//   is_new_ray     : one-cycle pulse at the start of a ray, clears the hit
//   is_wall        : current cell is a wall (combinational, zero latency)
//   hit_coord_x/y  : cell of the first wall hit on the current ray
module world_map
    import world_pkg::*;
#(
    parameter int MAP_W    = world_pkg::MAP_W,
    parameter int MAP_H    = world_pkg::MAP_H,
    parameter     MAP_FILE = ""
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] xPos,
    input  logic [3:0] yPos,
    input  logic       setup_complete,
    input  logic       is_new_ray,
    output logic       is_wall,
    output logic [3:0] hit_coord_x,
    output logic [3:0] hit_coord_y
);

    logic [MAP_W-1:0] row;
    logic             hit;

    world_map_rom #(
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H),
        .MAP_FILE (MAP_FILE)
    ) u_rom (
        .y   (yPos),
        .row (row)
    );

    // Combinational so the stepper halts on the wall cell itself.
    assign is_wall = setup_complete & row[xPos];

    // First-hit latch; a new ray takes priority over a same-edge capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit         <= 1'b0;
            hit_coord_x <= '0;
            hit_coord_y <= '0;
        end else if (is_new_ray) begin
            hit         <= 1'b0;
            hit_coord_x <= '0;
            hit_coord_y <= '0;
        end else if (is_wall && !hit) begin
            hit         <= 1'b1;
            hit_coord_x <= xPos;
            hit_coord_y <= yPos;
        end
    end

endmodule

// File: tb/tb_world_map.sv
module tb_world_map;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] xPos;
    logic [3:0] yPos;
    logic       setup_complete;
    logic       is_new_ray;
    logic       is_wall;
    logic [3:0] hit_coord_x;
    logic [3:0] hit_coord_y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb [$];

    world_map dut (
        .clk            (clk),
        .reset          (reset),
        .xPos           (xPos),
        .yPos           (yPos),
        .setup_complete (setup_complete),
        .is_new_ray     (is_new_ray),
        .is_wall        (is_wall),
        .hit_coord_x    (hit_coord_x),
        .hit_coord_y    (hit_coord_y)
    );

    always #5 clk = ~clk;

    // Independent description of the default map.
    function automatic logic ref_wall(input int x, input int y);
        if (x == 0 || x == 15 || y == 0 || y == 15) return 1'b1;
        if (x == 5 && (y == 5 || y == 6))           return 1'b1;
        if (y == 8 && (x == 10 || x == 11))         return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got %0h required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s: got %0h required %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk_wall(input string tag, input logic exp);
        push(tag, {7'd0, exp});
        #1;
        check({7'd0, is_wall});
    endtask

    task automatic chk_hit(input string tag, input logic [3:0] ex, input logic [3:0] ey);
        push(tag, {ex, ey});
        check({hit_coord_x, hit_coord_y});
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int walls;

        reset          = 1'b0;
        setup_complete = 1'b1;
        is_new_ray     = 1'b0;
        xPos           = 4'd3;
        yPos           = 4'd3;

        // Reset state, with a clock edge passing during reset.
        edge_then_settle();
        chk_hit("reset_hit", 4'd0, 4'd0);
        chk_wall("reset_wall_3_3", 1'b0);

        @(negedge clk);
        reset = 1'b1;
        xPos  = 4'd0;
        yPos  = 4'd7;
        chk_wall("wall_0_7_same_cycle", 1'b1);
        edge_then_settle();
        chk_hit("hit_0_7", 4'd0, 4'd7);

        // setup_complete gating, no clock edge between the two checks.
        @(negedge clk);
        setup_complete = 1'b0;
        xPos = 4'd0;
        yPos = 4'd0;
        chk_wall("gated_0_0", 1'b0);
        setup_complete = 1'b1;
        chk_wall("ungated_0_0", 1'b1);
        is_new_ray = 1'b1;
        edge_then_settle();
        chk_hit("clear_over_wall_0_0", 4'd0, 4'd0);

        // Step along row 5 towards the pillar.
        @(negedge clk);
        is_new_ray = 1'b0;
        yPos = 4'd5;
        for (int x = 2; x <= 5; x++) begin
            xPos = 4'(x);
            chk_wall($sformatf("step_x%0d_y5", x), x == 5);
            if (x != 5) begin
                edge_then_settle();
                chk_hit($sformatf("no_hit_x%0d", x), 4'd0, 4'd0);
                @(negedge clk);
            end
        end
        edge_then_settle();
        chk_hit("hit_5_5", 4'd5, 4'd5);

        // Further walls do not overwrite the latched hit.
        @(negedge clk);
        xPos = 4'd15;
        chk_wall("wall_15_5", 1'b1);
        edge_then_settle();
        chk_hit("hold_5_5", 4'd5, 4'd5);
        @(negedge clk);
        is_new_ray = 1'b1;
        edge_then_settle();
        chk_hit("new_ray_clear", 4'd0, 4'd0);
        @(negedge clk);
        is_new_ray = 1'b0;
        edge_then_settle();
        chk_hit("hit_15_5", 4'd15, 4'd5);

        // Clear and capture on the same edge: clear wins.
        @(negedge clk);
        is_new_ray = 1'b1;
        xPos = 4'd10;
        yPos = 4'd8;
        chk_wall("wall_10_8", 1'b1);
        edge_then_settle();
        chk_hit("clear_wins_10_8", 4'd0, 4'd0);
        @(negedge clk);
        is_new_ray = 1'b0;
        edge_then_settle();
        chk_hit("hit_10_8", 4'd10, 4'd8);

        // Asynchronous reset mid-ray, away from any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_hit("async_reset_clear", 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        xPos = 4'd11;
        yPos = 4'd8;
        edge_then_settle();
        chk_hit("hit_11_8_after_reset", 4'd11, 4'd8);

        // Full-map sweep against the reference map.
        walls = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                @(negedge clk);
                xPos = 4'(x);
                yPos = 4'(y);
                chk_wall($sformatf("sweep_%0d_%0d", x, y), ref_wall(x, y));
                if (is_wall === 1'b1) walls++;
            end
        end
        push("wall_count", 8'd64);
        check(8'(walls));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/world_map.md
Name: world_map

Overview:
- 16x16 tile-map lookup for the raycaster's DDA stepper.
- Given the current map cell (xPos, yPos), reports whether that cell is a wall.
- Latches the coordinates of the first wall cell hit on the current ray.
- Sits beside the ray calculator, which steps mapX/mapY until is_wall rises.

Parameters:
- MAP_W, 16, map width in cells; fixed by the 4-bit coordinates.
- MAP_H, 16, map height in cells.
- MAP_FILE, "" (empty), optional hex file of 16 rows x 16 bits (row y = line y, bit x = column x). Empty means the built-in default map is used.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- xPos  input  4  current map cell column (0-15).
- yPos  input  4  current map cell row (0-15).
- setup_complete  input  1  ray setup done; wall lookups are valid only while high.
- is_new_ray  input  1  single-cycle pulse marking the start of a new ray; clears the hit state.
- is_wall  output  1  current cell is a wall (qualified by setup_complete).
- hit_coord_x  output  4  column of the latched wall hit.
- hit_coord_y  output  4  row of the latched wall hit.

Behaviour:
- Map storage: 16 words of 16 bits, read-only during operation. Cell (x,y) is a wall iff map[y][x] == 1.
- Default map (used when MAP_FILE is empty):
  - All border cells are walls: x==0, x==15, y==0 or y==15.
  - Interior pillars at (5,5), (5,6), (10,8), (11,8).
  - Every other cell is 0.
- is_wall is combinational, zero-latency: is_wall = setup_complete & map[yPos][xPos].
  - This is required: the stepper must stop in the same cycle it lands on a wall cell, with no overshoot.
- is_wall is 0 whenever setup_complete is 0, regardless of position.
- Hit latch (registered):
  - On the first rising clock edge where is_wall == 1 and the hit flag is clear: capture hit_coord_x <= xPos, hit_coord_y <= yPos, and set the hit flag.
  - While the flag is set, further wall cycles do not change hit_coord.
- is_new_ray == 1 at a clock edge: clears the hit flag and zeroes hit_coord_x/y. This takes priority over a simultaneous capture.
- Reset (reset == 0), asynchronous: hit flag 0, hit_coord_x = 0, hit_coord_y = 0. is_wall follows its combinational equation (0 while setup_complete is low).
- Reset asserted mid-ray: hit state clears immediately; lookups resume when reset is released.
- Coordinates wrap naturally in 4 bits. Any 4-bit value is a legal index; no out-of-range case exists.
- No other state; no write port.

Decomposition:
- Package world_pkg holds:
  - MAP_W and MAP_H.
  - A cell coordinate typedef (4-bit).
  - A map row typedef (16-bit).
  - The default map constant: 16 row words, with row 0 and row 15 = 16'hFFFF, interior rows 16'h8001 plus the pillar bits.
- One natural sub-module, world_map_rom:
  - Holds the storage and its initialization: the MAP_FILE load or the default constant.
  - Provides a combinational read of one 16-bit row by yPos.
  - world_map selects bit xPos from that row and implements the hit latch.

Test Plan:
- Reset low with setup_complete=1 at (3,3) -> hit_coord_x=0, hit_coord_y=0, is_wall=0. Release reset, move to (0,7) -> is_wall=1 in the same cycle.
- setup_complete=0 at (0,0) -> is_wall=0. Raise setup_complete -> is_wall=1 combinationally.
- Step xPos 2,3,4,5 with yPos=5 and setup_complete=1 -> is_wall=0,0,0,1. After the next edge, hit_coord=(5,5).
- Hit latched at (5,5), then move to (15,5), which is also a wall -> hit_coord stays (5,5). Pulse is_new_ray -> hit_coord=(0,0) and hit flag clear. The next wall cell (15,5) is captured.
- is_new_ray and first wall hit at (10,8) on the same edge -> clear wins, hit_coord=(0,0). The following edge with is_wall=1 still held -> hit_coord=(10,8).
- Sweep all 256 cells with setup_complete=1 and compare is_wall against the default map. Expected wall count: 60 border + 4 pillars = 64.
